// File: rtl/wave_shaper.sv
// wave_shaper: maps oscillator count to an 8-bit square/saw/triangle/silence sample
// Ports: clk, rst (async, active-high), en (voice enable), divider[15:0] (note period),
//        count[15:0] (oscillator count 1..divider), wave_sel[1:0] (00 sq, 01 saw, 10 tri, 11 off),
//        sample[7:0] (unsigned, 8'h80 = silence), sample_valid, busy (scale divider running)
module wave_shaper #(
  parameter int DIV_BITS = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] divider,
  input  logic [15:0] count,
  input  logic [1:0]  wave_sel,
  output logic [7:0]  sample,
  output logic        sample_valid,
  output logic        busy
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] DIVIDE = 1'b1;
  logic [0:0]          r_state;
  logic [15:0]         r_lat;
  logic [15:0]         r_k;
  logic [15:0]         r_rem;
  logic [DIV_BITS-1:0] r_q;
  logic [4:0]          r_cnt;
  logic [31:0]         r_prod;
  logic                r_sq;
  logic [1:0]          r_sel1;
  logic                r_v1;
  logic [15:0]         w_eff;
  logic                w_nbit;
  logic [16:0]         w_rem_sh;
  logic                w_ge;
  logic [16:0]         w_rem_nx;
  logic [DIV_BITS-1:0] w_q_nx;
  logic                w_run;
  logic [7:0]          w_ramp;
  logic [7:0]          w_tri;
  logic [7:0]          w_shape;
  assign w_eff = (divider == 16'd0) ? 16'd1 : divider;
  assign busy = (r_state == DIVIDE);
  // numerator 24'hFF0000: only bits 23..16 are set
  assign w_nbit = (r_cnt >= 5'd16);
  assign w_rem_sh = {r_rem, w_nbit};
  assign w_ge = (w_rem_sh >= {1'b0, r_lat});
  assign w_rem_nx = w_ge ? w_rem_sh - {1'b0, r_lat} : w_rem_sh;
  assign w_q_nx = {r_q[DIV_BITS-2:0], w_ge};
  // hold the pipeline while a new divider is pending so stale K never reaches the output
  assign w_run = en && !busy && (w_eff == r_lat);
  assign w_ramp = (|r_prod[31:24]) ? 8'hFF : r_prod[23:16];
  assign w_tri = w_ramp[7] ? {~w_ramp[6:0], 1'b0} : {w_ramp[6:0], 1'b0};
  assign w_shape = (r_sel1 == 2'b00) ? (r_sq ? 8'hFF : 8'h00) :
                   (r_sel1 == 2'b01) ? w_ramp :
                   (r_sel1 == 2'b10) ? w_tri : 8'h80;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_lat   <= '0;
      r_k     <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
    end else if (!en) begin
      // clearing the latch forces a fresh division on re-enable
      r_state <= IDLE;
      r_lat   <= '0;
    end else if (w_eff != r_lat) begin
      r_state <= DIVIDE;
      r_lat   <= w_eff;
      r_cnt   <= 5'd23;
      r_rem   <= '0;
      r_q     <= '0;
    end else if (r_state == DIVIDE) begin
      r_rem <= w_rem_nx[15:0];
      r_q   <= w_q_nx;
      r_cnt <= r_cnt - 5'd1;
      if (r_cnt == 5'd0) begin
        r_k     <= (|w_q_nx[DIV_BITS-1:16]) ? 16'hFFFF : w_q_nx[15:0];
        r_state <= IDLE;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod       <= '0;
      r_sq         <= 1'b0;
      r_sel1       <= '0;
      r_v1         <= 1'b0;
      sample       <= 8'h80;
      sample_valid <= 1'b0;
    end else if (!en) begin
      r_v1         <= 1'b0;
      sample       <= 8'h80;
      sample_valid <= 1'b0;
    end else if (!w_run) begin
      r_v1         <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      r_prod       <= 32'(count) * 32'(r_k);
      r_sq         <= (count <= (r_lat >> 1));
      r_sel1       <= wave_sel;
      r_v1         <= 1'b1;
      sample_valid <= r_v1;
      if (r_v1) sample <= w_shape;
    end
  end
endmodule

// File: tb/tb_wave_shaper.sv
// tb_wave_shaper: directed checks of wave_shaper division timing, shaping and control
module tb_wave_shaper;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] divider;
  logic [15:0] count;
  logic [1:0]  wave_sel;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        busy;
  int total = 0;
  int bad = 0;
  int n;
  wave_shaper dut (
    .clk(clk), .rst(rst), .en(en), .divider(divider), .count(count),
    .wave_sel(wave_sel), .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick(input int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic div_wait(output int cyc);
    cyc = 0;
    tick();
    while (busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; divider = 16'd0; count = 16'd1; wave_sel = 2'b01;
    tick(2);
    chk("rst_sample", sample, 8'h80);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    en = 1'b1; divider = 16'd256;
    tick();
    chk("div_start_busy", busy, 1'b1);
    tick(3);
    rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_sample", sample, 8'h80);
    chk("async_rst_valid", sample_valid, 1'b0);
    tick();
    rst = 1'b0;
    div_wait(n);
    chk("busy_len_256", n, 24);
    chk("k_256", dut.r_k, 16'hFF00);
    wave_sel = 2'b10; count = 16'd128;
    tick();
    chk("tri_valid_lat1", sample_valid, 1'b0);
    tick();
    chk("tri_128", sample, 8'hFE);
    chk("tri_valid", sample_valid, 1'b1);
    count = 16'd256;
    tick();
    chk("tri_256_lat1", sample, 8'hFE);
    tick();
    chk("tri_256", sample, 8'h00);
    divider = 16'd22727; wave_sel = 2'b01; count = 16'd1;
    div_wait(n);
    chk("busy_len_22727", n, 24);
    chk("k_22727", dut.r_k, 16'd735);
    tick(2);
    chk("saw_1", sample, 8'h00);
    chk("saw_valid", sample_valid, 1'b1);
    count = 16'd11364;
    tick();
    chk("saw_mid_lat1", sample, 8'h00);
    tick();
    chk("saw_mid", sample, 8'h7F);
    count = 16'd22727;
    tick(2);
    chk("saw_top", sample, 8'hFE);
    count = 16'd1;
    tick();
    chk("saw_wrap_lat1", sample, 8'hFE);
    tick();
    chk("saw_wrap", sample, 8'h00);
    wave_sel = 2'b11;
    tick();
    chk("sel_lat1", sample, 8'h00);
    tick();
    chk("silence", sample, 8'h80);
    divider = 16'd30000; wave_sel = 2'b00; count = 16'd15000;
    div_wait(n);
    chk("busy_len_30000", n, 24);
    chk("k_30000", dut.r_k, 16'd557);
    chk("valid_after_div", sample_valid, 1'b0);
    tick(2);
    chk("sq_half", sample, 8'hFF);
    count = 16'd15001;
    tick(2);
    chk("sq_half_plus1", sample, 8'h00);
    divider = 16'd22727; wave_sel = 2'b01; count = 16'd30000;
    div_wait(n);
    tick(2);
    chk("saw_saturate", sample, 8'hFF);
    divider = 16'd25000;
    tick();
    chk("chg_busy", busy, 1'b1);
    chk("chg_valid", sample_valid, 1'b0);
    chk("chg_hold", sample, 8'hFF);
    tick(4);
    divider = 16'd30000;
    div_wait(n);
    chk("restart_len", n, 24);
    tick(2);
    chk("saw_30000_top", sample, 8'hFE);
    en = 1'b0;
    tick();
    chk("en_off_sample", sample, 8'h80);
    chk("en_off_valid", sample_valid, 1'b0);
    en = 1'b1;
    div_wait(n);
    chk("reen_len", n, 24);
    tick(2);
    chk("reen_saw", sample, 8'hFE);
    divider = 16'd22727;
    tick();
    chk("abort_busy_pre", busy, 1'b1);
    en = 1'b0;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_sample", sample, 8'h80);
    en = 1'b1;
    div_wait(n);
    chk("abort_redo_len", n, 24);
    tick(2);
    chk("abort_redo_saw", sample, 8'hFF);
    divider = 16'd0; count = 16'd1;
    div_wait(n);
    chk("busy_len_0", n, 24);
    chk("k_0", dut.r_k, 16'hFFFF);
    tick(2);
    chk("div0_saw_1", sample, 8'h00);
    chk("div0_valid", sample_valid, 1'b1);
    count = 16'd200;
    tick(2);
    chk("div0_saw_200", sample, 8'hC7);
    count = 16'd300;
    tick(2);
    chk("div0_saw_300", sample, 8'hFF);
    divider = 16'd1; count = 16'd1;
    tick();
    chk("div1_no_busy", busy, 1'b0);
    tick();
    chk("div1_saw_1", sample, 8'h00);
    chk("div1_valid", sample_valid, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
